// File: rtl/dbg_display_ctrl.sv
// Debug display controller: probe mux, arm/trigger/capture FSM, active-low 7-seg digits and event LED stretchers.
// Define DBG_DISP_BLANK_EN to blank leading-zero digits (digit 0 is always shown).
module dbg_display_ctrl #(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 32,
  parameter int NUM_DIGITS  = 8,
  parameter int NUM_EV      = 9,
  parameter int STRETCH_CYC = 2**22,
  localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     arm,
  input  logic                     clr,
  input  logic                     trig,
  input  logic [NUM_EV-1:0]        events,
  output logic [DATA_W-1:0]        display_val,
  output logic [NUM_DIGITS*7-1:0]  hex_seg,
  output logic [NUM_EV-1:0]        ev_led,
  output logic [1:0]               cap_state
);

  localparam int CNT_W = $clog2(STRETCH_CYC + 1);

  typedef enum logic [1:0] {
    LIVE     = 2'd0,
    ARMED    = 2'd1,
    CAPTURED = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       display_val_q, display_val_d;
  logic [DATA_W-1:0]       mux_val;
  logic [CNT_W-1:0]        cnt_q [NUM_EV];
  logic [CNT_W-1:0]        cnt_d [NUM_EV];
  logic [NUM_EV-1:0]       ev_led_q, ev_led_d;
  logic [4*NUM_DIGITS-1:0] disp_ext;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Unmatched select codes fall through to zero.
  always_comb begin
    mux_val = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(sel) == k) mux_val = ch_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d       = state_q;
    display_val_d = display_val_q;
    if (clr) begin
      state_d       = LIVE;
      display_val_d = mux_val;
    end else if (arm) begin
      state_d       = ARMED;
      display_val_d = mux_val;
    end else begin
      case (state_q)
        LIVE: display_val_d = mux_val;
        ARMED: begin
          display_val_d = mux_val;
          if (trig) state_d = CAPTURED;
        end
        default: display_val_d = display_val_q;
      endcase
    end
  end

  // A new event reloads the counter rather than extending it.
  always_comb begin
    for (int i = 0; i < NUM_EV; i++) begin
      cnt_d[i] = cnt_q[i];
      if (events[i]) cnt_d[i] = CNT_W'(STRETCH_CYC);
      else if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_W'(1);
      ev_led_d[i] = (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LIVE;
      display_val_q <= '0;
      ev_led_q      <= '0;
      for (int i = 0; i < NUM_EV; i++) cnt_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      display_val_q <= display_val_d;
      ev_led_q      <= ev_led_d;
      for (int i = 0; i < NUM_EV; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    disp_ext               = '0;
    disp_ext[DATA_W-1:0]   = display_val_q;
  end

`ifdef DBG_DISP_BLANK_EN
  logic lead;

  // Scan from the top digit down; blank until the first nonzero nibble.
  always_comb begin
    hex_seg = '0;
    lead    = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      if (disp_ext[d*4 +: 4] != 4'h0) lead = 1'b0;
      hex_seg[d*7 +: 7] = (lead && d != 0) ? 7'b1111111 : seg7(disp_ext[d*4 +: 4]);
    end
  end
`else
  always_comb begin
    hex_seg = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      hex_seg[d*7 +: 7] = seg7(disp_ext[d*4 +: 4]);
    end
  end
`endif

  assign display_val = display_val_q;
  assign ev_led      = ev_led_q;
  assign cap_state   = state_q;

endmodule

// File: tb/tb_dbg_display_ctrl.sv
// Testbench for dbg_display_ctrl: directed steps, reference model feeding a scoreboard queue.
// A second instance with NUM_CH=5 exercises out-of-range channel select.
module tb_dbg_display_ctrl;

  localparam int NUM_CH  = 8;
  localparam int DATA_W  = 32;
  localparam int NUM_DIG = 8;
  localparam int NUM_EV  = 9;
  localparam int STRETCH = 5;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;
  localparam logic [6:0] BL = 7'b1111111;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_CH*DATA_W-1:0]  ch_data = '0;
  logic [2:0]                sel = '0;
  logic                      arm = 1'b0, clr = 1'b0, trig = 1'b0;
  logic [NUM_EV-1:0]         events = '0;
  logic [DATA_W-1:0]         display_val;
  logic [NUM_DIG*7-1:0]      hex_seg;
  logic [NUM_EV-1:0]         ev_led;
  logic [1:0]                cap_state;

  logic [5*DATA_W-1:0]       ch_data2 = '0;
  logic [2:0]                sel2 = '0;
  logic [DATA_W-1:0]         display_val2;
  logic [NUM_DIG*7-1:0]      hex_seg2;
  logic [0:0]                ev_led2;
  logic [1:0]                cap_state2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0]       val;
    logic [1:0]        st;
    logic [NUM_EV-1:0] led;
  } exp_t;

  exp_t        sb_q[$];
  int          m_state;
  logic [31:0] m_val;
  int          m_cnt [NUM_EV];

  dbg_display_ctrl #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .NUM_DIGITS(NUM_DIG), .NUM_EV(NUM_EV), .STRETCH_CYC(STRETCH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .sel(sel), .arm(arm), .clr(clr), .trig(trig),
    .events(events), .display_val(display_val), .hex_seg(hex_seg), .ev_led(ev_led), .cap_state(cap_state)
  );

  dbg_display_ctrl #(
    .NUM_CH(5), .DATA_W(DATA_W), .NUM_DIGITS(NUM_DIG), .NUM_EV(1), .STRETCH_CYC(3)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .ch_data(ch_data2), .sel(sel2), .arm(1'b0), .clr(1'b0), .trig(1'b0),
    .events(1'b0), .display_val(display_val2), .hex_seg(hex_seg2), .ev_led(ev_led2), .cap_state(cap_state2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fixed_word(input int k);
    return 32'h0B00_0000 | (32'(k) * 32'h1111);
  endfunction

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_state = 0;
    m_val   = '0;
    for (int i = 0; i < NUM_EV; i++) m_cnt[i] = 0;
  endtask

  // Drive one cycle of inputs and push the model's expected post-edge outputs.
  task automatic applyStimulus(input logic [31:0] c0, input logic [31:0] c1, input logic [2:0] s,
                               input logic a, input logic c, input logic t, input logic [NUM_EV-1:0] ev);
    logic [31:0] words [NUM_CH];
    exp_t        e;
    for (int k = 0; k < NUM_CH; k++) words[k] = fixed_word(k);
    words[0] = c0;
    words[1] = c1;
    for (int k = 0; k < NUM_CH; k++) ch_data[k*DATA_W +: DATA_W] = words[k];
    sel = s; arm = a; clr = c; trig = t; events = ev;
    if (c) begin
      m_state = 0; m_val = words[s];
    end else if (a) begin
      m_state = 1; m_val = words[s];
    end else if (m_state == 0) begin
      m_val = words[s];
    end else if (m_state == 1) begin
      m_val = words[s];
      if (t) m_state = 2;
    end
    for (int i = 0; i < NUM_EV; i++) begin
      if (ev[i]) m_cnt[i] = STRETCH;
      else if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
      e.led[i] = (m_cnt[i] != 0);
    end
    e.val = m_val;
    e.st  = 2'(m_state);
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("[TB] FAIL %s.underflow: observed=%0d expected=1 entries", tag, sb_q.size());
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checkValue({tag, ".val"}, 64'(display_val), 64'(e.val));
      checkValue({tag, ".state"}, 64'(cap_state), 64'(e.st));
      checkValue({tag, ".led"}, 64'(ev_led), 64'(e.led));
    end
  endtask

  initial begin
    logic [NUM_DIG*7-1:0] hex_zero, hex_1234, hex_89ab, hex_0567;
`ifdef DBG_DISP_BLANK_EN
    hex_zero = {BL, BL, BL, BL, BL, BL, BL, S0};
    hex_1234 = {BL, BL, BL, BL, S1, S2, S3, S4};
    hex_0567 = {BL, S5, S6, S7, S0, S0, S0, S0};
`else
    hex_zero = {S0, S0, S0, S0, S0, S0, S0, S0};
    hex_1234 = {S0, S0, S0, S0, S1, S2, S3, S4};
    hex_0567 = {S0, S5, S6, S7, S0, S0, S0, S0};
`endif
    hex_89ab = {S8, S9, SA, SB, SC, SD, SE, SF};

    for (int k = 0; k < 5; k++) ch_data2[k*DATA_W +: DATA_W] = 32'hFFFF_FFF0 | 32'(k);
    modelReset();
    ch_data[1*DATA_W +: DATA_W] = 32'h0000_1234;
    sel = 3'd1;
    repeat (3) @(posedge clk);
    #1;
    checkValue("reset.val", 64'(display_val), 64'h0);
    checkValue("reset.state", 64'(cap_state), 64'h0);
    checkValue("reset.led", 64'(ev_led), 64'h0);
    checkValue("reset.hex", 64'(hex_seg), 64'(hex_zero));
    rst_n = 1'b1;

    applyStimulus(32'h0, 32'h0000_1234, 3'd1, 0, 0, 0, '0);
    sel2 = 3'd6;
    checkOutput("release");
    checkValue("hex_1234", 64'(hex_seg), 64'(hex_1234));
    checkValue("oor.val", 64'(display_val2), 64'h0);
    checkValue("oor.hex", 64'(hex_seg2), 64'(hex_zero));
    sel2 = 3'd4;
    applyStimulus(32'h89AB_CDEF, 32'h0000_1234, 3'd0, 0, 0, 0, '0);
    checkOutput("sel0");
    checkValue("hex_89ab", 64'(hex_seg), 64'(hex_89ab));
    checkValue("top_ch.val", 64'(display_val2), 64'hFFFF_FFF4);
    applyStimulus(32'h0567_0000, 32'h0, 3'd0, 0, 0, 0, '0);
    checkOutput("sel0b");
    checkValue("hex_0567", 64'(hex_seg), 64'(hex_0567));
    applyStimulus(32'h0, 32'h0, 3'd7, 0, 0, 1, '0);
    checkOutput("sel7_trig_live");

    applyStimulus(32'h0, 32'd100, 3'd1, 1, 0, 1, '0);
    checkOutput("arm_trig_same");
    applyStimulus(32'h0, 32'd101, 3'd1, 0, 0, 1, '0);
    checkOutput("capture");
    checkValue("capture.state", 64'(cap_state), 64'd2);
    for (int n = 0; n < 100; n++) begin
      applyStimulus(32'(n), 32'd200 + 32'(n), 3'(n % 8), 0, 0, 1'(n % 2), '0);
      checkOutput("hold");
    end
    checkValue("hold.final", 64'(display_val), 64'd101);

    applyStimulus(32'h0, 32'd500, 3'd1, 1, 0, 0, '0);
    checkOutput("rearm");
    checkValue("rearm.state", 64'(cap_state), 64'd1);
    applyStimulus(32'h0, 32'd501, 3'd1, 0, 0, 0, '0);
    checkOutput("rearm_track");
    applyStimulus(32'h0, 32'd502, 3'd1, 1, 1, 1, '0);
    checkOutput("arm_clr");
    checkValue("arm_clr.state", 64'(cap_state), 64'd0);

    applyStimulus(32'h0, 32'd1, 3'd1, 0, 0, 0, 9'h008);
    checkOutput("ev3_pulse");
    for (int n = 0; n < 5; n++) begin
      applyStimulus(32'h0, 32'd1, 3'd1, 0, 0, 0, '0);
      checkOutput("ev3_tail");
      checkValue("ev3_led", 64'(ev_led[3]), 64'(n < 4));
    end
    applyStimulus(32'h0, 32'd2, 3'd1, 0, 0, 0, 9'h108);
    checkOutput("retrig_a");
    repeat (2) begin
      applyStimulus(32'h0, 32'd2, 3'd1, 0, 0, 0, '0);
      checkOutput("retrig_gap");
    end
    applyStimulus(32'h0, 32'd3, 3'd1, 0, 0, 0, 9'h008);
    checkOutput("retrig_b");
    for (int n = 0; n < 5; n++) begin
      applyStimulus(32'h0, 32'd3, 3'd1, 0, 0, 0, '0);
      checkOutput("retrig_tail");
      checkValue("retrig_led", 64'(ev_led[3]), 64'(n < 4));
    end

    applyStimulus(32'h0, 32'd7, 3'd1, 1, 0, 0, 9'h008);
    checkOutput("pre_reset_arm");
    applyStimulus(32'h0, 32'd8, 3'd1, 0, 0, 0, '0);
    checkOutput("pre_reset_lit");
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("async_reset.state", 64'(cap_state), 64'd0);
    checkValue("async_reset.led", 64'(ev_led), 64'd0);
    checkValue("async_reset.val", 64'(display_val), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
